// File: rtl/skew_feeder.sv
// Skewed operand feeder: pops the per-row FIFOs in diagonal order and drives
// registered, zero-padded operands plus a step strobe into the systolic array.
module skew_feeder #(
   parameter int ROWS      = 32,
   parameter int ROWS_LOG2 = 5,
   parameter int BWIDTH    = 8,
   parameter int LWIDTH    = 8
) (
   input  logic                   CLK,
   input  logic                   RSTn,
   input  logic                   START,
   input  logic [LWIDTH-1:0]      LEN,
   input  logic [ROWS-1:0]        FIFO_EMPTY,
   input  logic [ROWS*BWIDTH-1:0] FIFO_DOUT,
   output logic [ROWS-1:0]        FIFO_POPE,
   output logic [ROWS*BWIDTH-1:0] A_OUT,
   output logic [ROWS-1:0]        A_VALID,
   output logic                   ADV,
   output logic                   BUSY,
   output logic                   DONE
);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t                 state_q, state_d;
   logic [LWIDTH:0]        cnt_q, cnt_d;
   logic [LWIDTH-1:0]      len_q, len_d;
   logic [ROWS*BWIDTH-1:0] aOut_q, aOut_d;
   logic [ROWS-1:0]        aValid_q, aValid_d;
   logic                   adv_q, adv_d;
   logic [ROWS-1:0]        active;
   logic                   go;
   logic [LWIDTH:0]        lastStep;

   // Row i is inside its diagonal window while 0 <= cnt-i < LEN.
   for (genvar i = 0; i < ROWS; i++) begin : gRow
      localparam logic [ROWS_LOG2-1:0] ROW_ID  = ROWS_LOG2'(i);
      localparam logic [LWIDTH:0]      ROW_OFS = (LWIDTH+1)'(ROW_ID);
      assign active[i] = (state_q == RUN) && (cnt_q >= ROW_OFS) &&
                         ((cnt_q - ROW_OFS) < {1'b0, len_q});
   end

   assign go        = ~|(active & FIFO_EMPTY);
   assign FIFO_POPE = go ? active : '0;
   assign lastStep  = {1'b0, len_q} + (LWIDTH+1)'(ROWS - 2);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      len_d    = len_q;
      aOut_d   = aOut_q;
      aValid_d = '0;
      adv_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (START) begin
               if (LEN != '0) begin
                  len_d   = LEN;
                  cnt_d   = '0;
                  state_d = RUN;
               end else begin
                  state_d = FIN;
               end
            end
         end
         RUN: begin
            if (go) begin
               adv_d    = 1'b1;
               aValid_d = active;
               for (int r = 0; r < ROWS; r++) begin
                  aOut_d[r*BWIDTH +: BWIDTH] = active[r] ? FIFO_DOUT[r*BWIDTH +: BWIDTH] : '0;
               end
               // The final diagonal leaves RUN instead of incrementing, so cnt never wraps.
               if (cnt_q == lastStep) begin
                  state_d = FIN;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         len_q    <= '0;
         aOut_q   <= '0;
         aValid_q <= '0;
         adv_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         len_q    <= len_d;
         aOut_q   <= aOut_d;
         aValid_q <= aValid_d;
         adv_q    <= adv_d;
      end
   end

   assign A_OUT   = aOut_q;
   assign A_VALID = aValid_q;
   assign ADV     = adv_q;
   assign BUSY    = (state_q != IDLE);
   assign DONE    = (state_q == FIN);

endmodule
